// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: assembles a 32-bit instruction from four
// byte reads of a byte-wide instruction memory and holds it under a
// single-entry tag so a repeated PC is served without stalling.
module instr_fetch_ctrl #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [31:0]       instruction_o,
  output logic              busywait_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  input  logic [7:0]        mem_readdata_i,
  input  logic              mem_busywait_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] lpc_q;
  logic [ADDR_W-1:0] tag_q;
  logic              tag_valid_q;
  logic              flush_pend_q;
  logic [31:0]       instr_q;
  // Bytes 0..2 of the instruction being assembled; byte 3 arrives on the
  // completing edge and goes straight into the instruction register.
  logic [23:0]       asm_q;

  logic              hit;
  logic [31:0]       instr_d;

  // Hit detection and the completed word formed on the final byte capture.
  always_comb begin
    hit     = tag_valid_q && (tag_q == pc_i) && !flush_i;
    instr_d = {mem_readdata_i, asm_q};
  end

  // Memory-side and stall outputs decoded straight from the state flops.
  always_comb begin
    mem_read_o = (state_q == FETCH);
    mem_addr_o = '0;
    if (state_q == FETCH) begin
      // Unsigned add of the byte offset wraps naturally at 2^ADDR_W.
      mem_addr_o = lpc_q + ADDR_W'(cnt_q);
    end
    busywait_o = (state_q == FETCH) || !hit;
  end

  assign instruction_o = instr_q;

  // Fetch FSM with its counter, address latch, tag and assembly state.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is sampled on the clock edge here, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (reset_i) begin
      // NOTE: all state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      lpc_q        <= '0;
      tag_q        <= '0;
      tag_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      instr_q      <= RESET_INSTR;
      asm_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            tag_valid_q <= 1'b0;
          end
          if (!hit) begin
            lpc_q   <= pc_i;
            cnt_q   <= 2'd0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (flush_i) begin
            flush_pend_q <= 1'b1;
          end
          if (!mem_busywait_i) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
              2'd0: asm_q[7:0]   <= mem_readdata_i;
              2'd1: asm_q[15:8]  <= mem_readdata_i;
              2'd2: asm_q[23:16] <= mem_readdata_i;
              default: begin
                instr_q      <= instr_d;
                tag_q        <= lpc_q;
                // A flush seen at any point of the fetch leaves the tag invalid.
                tag_valid_q  <= !(flush_pend_q || flush_i);
                flush_pend_q <= 1'b0;
                state_q      <= IDLE;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a byte-wide memory model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RST_INSTR = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instruction;
  logic        busywait;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_readdata;
  logic        mem_busywait;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];

  instr_fetch_ctrl #(
    .ADDR_W      (32),
    .RESET_INSTR (RST_INSTR)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .pc_i           (pc),
    .flush_i        (flush),
    .instruction_o  (instruction),
    .busywait_o     (busywait),
    .mem_addr_o     (mem_addr),
    .mem_read_o     (mem_read),
    .mem_readdata_i (mem_readdata),
    .mem_busywait_i (mem_busywait)
  );

  assign mem_readdata = mem[mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_cycle(input string tag, input logic [31:0] addr);
    check({tag, "_read"}, {31'd0, mem_read}, 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_busy"}, {31'd0, busywait}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // 0x00030006 at 0, 0x01040003 at 4, 0x00030002 at 8, 0x44332211 at 12
    mem[0]  = 8'h06; mem[1]  = 8'h00; mem[2]  = 8'h03; mem[3]  = 8'h00;
    mem[4]  = 8'h03; mem[5]  = 8'h00; mem[6]  = 8'h04; mem[7]  = 8'h01;
    mem[8]  = 8'h02; mem[9]  = 8'h00; mem[10] = 8'h03; mem[11] = 8'h00;
    mem[12] = 8'h11; mem[13] = 8'h22; mem[14] = 8'h33; mem[15] = 8'h44;
    mem[254] = 8'hEE; mem[255] = 8'hFF;

    reset = 1'b1; pc = 32'd0; flush = 1'b0; mem_busywait = 1'b0;
    go(); go();
    reset = 1'b0;
    #1;
    // Cycle 0 after reset release
    check("rst_instr", instruction, RST_INSTR);
    check("rst_read", {31'd0, mem_read}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_busy", {31'd0, busywait}, 32'd1);

    // Zero-wait fetch of PC=0: addresses 0..3, done at cycle 5
    for (int i = 0; i < 4; i++) begin
      go();
      fetch_cycle("f0", 32'(i));
      check("f0_hold", instruction, RST_INSTR);
    end
    go();
    check("f0_busy", {31'd0, busywait}, 32'd0);
    check("f0_instr", instruction, 32'h0003_0006);
    check("f0_read", {31'd0, mem_read}, 32'd0);
    go();
    check("f0_hit_busy", {31'd0, busywait}, 32'd0);
    check("f0_hit_read", {31'd0, mem_read}, 32'd0);

    // PC=4 with two wait cycles on byte 5: 7 stall cycles
    pc = 32'd4;
    #1;
    check("w_a0_busy", {31'd0, busywait}, 32'd1);
    check("w_a0_read", {31'd0, mem_read}, 32'd0);
    go(); fetch_cycle("w_a1", 32'd4);
    go(); mem_busywait = 1'b1; #1; fetch_cycle("w_a2", 32'd5);
    go(); fetch_cycle("w_a3", 32'd5);
    check("w_a3_hold", instruction, 32'h0003_0006);
    go(); mem_busywait = 1'b0; #1; fetch_cycle("w_a4", 32'd5);
    go(); fetch_cycle("w_a5", 32'd6);
    go(); fetch_cycle("w_a6", 32'd7);
    go();
    check("w_done_busy", {31'd0, busywait}, 32'd0);
    check("w_done_instr", instruction, 32'h0104_0003);

    // Held PC hits; a flush pulse causes exactly one refetch
    go();
    check("h_busy", {31'd0, busywait}, 32'd0);
    check("h_read", {31'd0, mem_read}, 32'd0);
    go();
    flush = 1'b1;
    #1;
    check("fl_busy", {31'd0, busywait}, 32'd1);
    go();
    flush = 1'b0;
    #1;
    fetch_cycle("fl_b0", 32'd4);
    go(); fetch_cycle("fl_b1", 32'd5);
    go(); fetch_cycle("fl_b2", 32'd6);
    go(); fetch_cycle("fl_b3", 32'd7);
    go();
    check("fl_done_busy", {31'd0, busywait}, 32'd0);
    check("fl_done_instr", instruction, 32'h0104_0003);
    go();
    check("fl_once_read", {31'd0, mem_read}, 32'd0);
    check("fl_once_busy", {31'd0, busywait}, 32'd0);

    // PC changes 8 -> 12 during byte 1: 8 completes, then 12 is fetched
    pc = 32'd8;
    #1;
    check("pc_c0_busy", {31'd0, busywait}, 32'd1);
    go(); fetch_cycle("pc_c1", 32'd8);
    go(); pc = 32'd12; #1; fetch_cycle("pc_c2", 32'd9);
    go(); fetch_cycle("pc_c3", 32'd10);
    go(); fetch_cycle("pc_c4", 32'd11);
    go();
    check("pc_c5_instr", instruction, 32'h0003_0002);
    check("pc_c5_busy", {31'd0, busywait}, 32'd1);
    check("pc_c5_read", {31'd0, mem_read}, 32'd0);
    go(); fetch_cycle("pc_c6", 32'd12);
    go(); fetch_cycle("pc_c7", 32'd13);
    go(); fetch_cycle("pc_c8", 32'd14);
    go(); fetch_cycle("pc_c9", 32'd15);
    go();
    check("pc_c10_busy", {31'd0, busywait}, 32'd0);
    check("pc_c10_instr", instruction, 32'h4433_2211);

    // Reset while CNT=2 aborts the fetch; clean refetch follows
    pc = 32'd0;
    #1;
    check("mr_d0_busy", {31'd0, busywait}, 32'd1);
    go(); fetch_cycle("mr_d1", 32'd0);
    go(); fetch_cycle("mr_d2", 32'd1);
    go(); fetch_cycle("mr_d3", 32'd2);
    reset = 1'b1;
    go();
    reset = 1'b0;
    #1;
    check("mr_d4_read", {31'd0, mem_read}, 32'd0);
    check("mr_d4_instr", instruction, RST_INSTR);
    check("mr_d4_busy", {31'd0, busywait}, 32'd1);
    check("mr_d4_addr", mem_addr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      go();
      fetch_cycle("mr_re", 32'(i));
    end
    go();
    check("mr_done_busy", {31'd0, busywait}, 32'd0);
    check("mr_done_instr", instruction, 32'h0003_0006);

    // Address wrap at the top of the address space
    pc = 32'hFFFF_FFFE;
    #1;
    check("wr_e0_busy", {31'd0, busywait}, 32'd1);
    go(); fetch_cycle("wr_e1", 32'hFFFF_FFFE);
    go(); fetch_cycle("wr_e2", 32'hFFFF_FFFF);
    go(); fetch_cycle("wr_e3", 32'h0000_0000);
    go(); fetch_cycle("wr_e4", 32'h0000_0001);
    go();
    check("wr_done_busy", {31'd0, busywait}, 32'd0);
    check("wr_done_instr", instruction, 32'h0006_FFEE);

    // Flush during a fetch leaves the tag invalid, forcing one more fetch
    pc = 32'd4;
    go(); fetch_cycle("fp_f1", 32'd4);
    go(); flush = 1'b1; #1; fetch_cycle("fp_f2", 32'd5);
    go(); flush = 1'b0; #1; fetch_cycle("fp_f3", 32'd6);
    go(); fetch_cycle("fp_f4", 32'd7);
    go();
    check("fp_f5_instr", instruction, 32'h0104_0003);
    check("fp_f5_busy", {31'd0, busywait}, 32'd1);
    go(); fetch_cycle("fp_f6", 32'd4);
    go(); fetch_cycle("fp_f7", 32'd5);
    go(); fetch_cycle("fp_f8", 32'd6);
    go(); fetch_cycle("fp_f9", 32'd7);
    go();
    check("fp_f10_busy", {31'd0, busywait}, 32'd0);
    check("fp_f10_instr", instruction, 32'h0104_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of PC and MEM_ADDR.
REQ-002 Parameter RESET_INSTR, default 32'h0000_0000, SHALL set the INSTRUCTION value after reset.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be synchronous and active-high.
REQ-005 PC  input  ADDR_W  SHALL be the processor byte address of the instruction to fetch.
REQ-006 FLUSH  input  1  SHALL invalidate the held instruction.
REQ-007 INSTRUCTION  output  32  SHALL be the fetched instruction, registered.
REQ-008 BUSYWAIT  output  1  SHALL stall the processor: high = INSTRUCTION not valid for the current PC.
REQ-009 MEM_ADDR  output  ADDR_W  SHALL be the byte address presented to instruction memory.
REQ-010 MEM_READ  output  1  SHALL be the byte read request.
REQ-011 MEM_READDATA  input  8  SHALL be the byte returned by memory.
REQ-012 MEM_BUSYWAIT  input  1  SHALL be high while memory is not ready; data is valid when MEM_READ=1 and MEM_BUSYWAIT=0.

Function
REQ-013 FSM SHALL have two states: IDLE and FETCH, with a 2-bit byte counter CNT, a latched address LPC, a TAG register and TAG_VALID.
REQ-014 HIT SHALL be defined as TAG_VALID=1, TAG==PC and FLUSH=0.
REQ-015 BUSYWAIT SHALL be combinational: high in FETCH, and high in IDLE when HIT=0.
REQ-016 IDLE with HIT=0 SHALL latch LPC<=PC, set CNT<=0 and go to FETCH on the next edge.
REQ-017 IDLE with HIT=1 SHALL stay in IDLE, with MEM_READ=0.
REQ-018 FETCH SHALL drive MEM_READ=1 and MEM_ADDR=LPC+CNT, with modulo 2^ADDR_W wrap.
REQ-019 On a FETCH edge with MEM_BUSYWAIT=0, MEM_READDATA SHALL be captured into byte lane CNT (little-endian: CNT=0 -> bits 7:0, CNT=3 -> bits 31:24) and CNT SHALL increment.
REQ-020 On a FETCH edge with MEM_BUSYWAIT=1, all state SHALL hold, as SHALL MEM_ADDR and MEM_READ.
REQ-021 On the capture with CNT=3, the controller SHALL update INSTRUCTION with all 4 bytes, set TAG<=LPC and TAG_VALID<=1 (unless a flush is pending), and return to IDLE.
REQ-022 INSTRUCTION SHALL change only on the REQ-021 edge or on reset; partial bytes SHALL be held in a separate assembly register.
REQ-023 Zero-wait latency SHALL be as follows: a PC change at cycle 0 gives BUSYWAIT high for cycles 0-4 and low at cycle 5 with the new INSTRUCTION; each memory wait cycle adds one cycle.
REQ-024 A PC change during FETCH SHALL be ignored until completion; the next IDLE compare then misses and refetches.
REQ-025 FLUSH in IDLE SHALL clear TAG_VALID; the same cycle counts as a miss.
REQ-026 FLUSH during FETCH SHALL set a pending flag so that completion leaves TAG_VALID=0; the flag SHALL clear on return to IDLE.
REQ-027 PC SHALL need no alignment: misaligned PC fetches bytes PC..PC+3.

Reset
REQ-028 While RESET=1 at an edge, the controller SHALL set state=IDLE, CNT=0, TAG_VALID=0, TAG=0, pending flush=0, INSTRUCTION=RESET_INSTR, and the assembly register to 0.
REQ-029 Outputs after reset SHALL be MEM_READ=0 and MEM_ADDR=0; BUSYWAIT follows REQ-015, so it is high after reset.
REQ-030 RESET mid-FETCH SHALL abort the fetch with no INSTRUCTION or TAG update; the first post-reset cycle refetches the current PC.

Verification
REQ-031 Zero-wait memory holding 32'h0003_0006 at bytes 0-3, PC=0 after reset -> MEM_ADDR 0,1,2,3 on consecutive cycles, INSTRUCTION=32'h0003_0006, and BUSYWAIT low 5 cycles after reset release.
REQ-032 PC=4 with MEM_BUSYWAIT held high 2 cycles on byte 5 -> MEM_ADDR holds 5 for 3 cycles, INSTRUCTION=32'h0104_0003, and BUSYWAIT high for 7 cycles total.
REQ-033 PC held at 4 after the fetch completes -> no MEM_READ, BUSYWAIT low; FLUSH pulse -> exactly one 4-byte refetch.
REQ-034 PC changes 8->12 during the byte-1 fetch -> the fetch completes for 8 (INSTRUCTION=32'h0003_0002 for one cycle), then 12 is fetched, with BUSYWAIT high throughout.
REQ-035 RESET asserted while CNT=2 -> the next cycle shows MEM_READ=0 and INSTRUCTION=RESET_INSTR; a clean refetch of the current PC follows.
REQ-036 PC=32'hFFFF_FFFE -> MEM_ADDR sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
